// File: rtl/tpu_pkg.sv
// tpu_pkg: shared defaults and types for the systolic-array result path.
//   DATA_W_DEF / N_COLS_DEF : default accumulator width and column count
//   LANE_W                  : width of one column lane in a packed row
//   drain_state_t           : result_drain collector FSM states
package tpu_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned N_COLS_DEF = 2;
  localparam int unsigned LANE_W     = DATA_W_DEF;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } drain_state_t;

endpackage

// File: rtl/result_drain_if.sv
// result_drain_if: de-skewed row stream leaving result_drain.
//   out_valid : row available
//   out_ready : sink accepts the row
//   out_data  : packed row, column c in bits [c*DATA_W +: DATA_W]
//   out_last  : row is the final row of the job
// Modports: master = row source (result_drain), slave = row sink.
interface result_drain_if #(
  parameter int unsigned DATA_W = tpu_pkg::LANE_W,
  parameter int unsigned N_COLS = tpu_pkg::N_COLS_DEF
);

  logic                     out_valid;
  logic                     out_ready;
  logic [N_COLS*DATA_W-1:0] out_data;
  logic                     out_last;

  modport master (
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: row buffer with a registered head (no fall-through).
//   clk, reset     : clock, asynchronous active-low reset
//   flush          : empty the FIFO (dout keeps its value)
//   push, din      : write request and data
//   pop            : read request (ignored when empty)
//   dout           : head row, registered; holds its last value when empty
//   empty, count   : occupancy flags
//   drop           : push refused because full with no simultaneous pop
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr, rptr_nx;
  logic             full, pop_ok, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;
  assign rptr_nx = rptr + AW'(1);

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr_nx;
      count <= count + CW'(push_ok) - CW'(pop_ok);
      // Head register: load the incoming row when it becomes the head
      // (empty, or popping the only stored row), else the next stored row.
      if (empty && push_ok) begin
        dout <= din;
      end else if (pop_ok) begin
        if (count > CW'(1))  dout <= mem[rptr_nx];
        else if (push_ok)    dout <= din;
      end
    end
  end

endmodule

// File: rtl/result_drain.sv
// result_drain: collects skewed per-column accumulator results from the
// systolic array, de-skews them into rows, buffers them and streams them out.
//   clk, reset     : clock, asynchronous active-low reset
//   start          : 1-cycle pulse, flush and begin a job
//   rows_expected  : rows in the job, sampled on start (0 means 1)
//   acc_valid_in   : per-column result valid, column c lags column 0 by c cycles
//   acc_in         : per-column results, column c in [c*DATA_W +: DATA_W]
//   out_if         : row stream (result_drain_if.master)
//   done           : 1-cycle pulse after the final row is popped
//   overflow       : sticky, a row was dropped on a full FIFO
//   skew_err       : sticky, aligned column valids disagreed
// Build option: RESULT_RELU_EN clamps negative columns to 0 at push time.
module result_drain
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W = LANE_W,
  parameter int unsigned N_COLS = N_COLS_DEF,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_W-1:0]         rows_expected,
  input  logic [N_COLS-1:0]        acc_valid_in,
  input  logic [N_COLS*DATA_W-1:0] acc_in,
  result_drain_if.master           out_if,
  output logic                     done,
  output logic                     overflow,
  output logic                     skew_err
);

  localparam int unsigned ROW_W = N_COLS * DATA_W;
  localparam int unsigned FCW   = $clog2(DEPTH) + 1;

  drain_state_t     state, state_nx;
  logic [N_COLS-1:0] al_valid;
  logic [ROW_W-1:0]  al_row, push_data, fifo_dout;
  logic [CNT_W-1:0]  target, pushed_cnt, popped_cnt;
  logic [FCW-1:0]    fifo_count;
  logic              fifo_empty, fifo_drop, push_req, skew_hit, pop;

  // Column c is delayed N_COLS-1-c cycles so every column lines up with the last.
  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    localparam int unsigned D = N_COLS - 1 - c;
    if (D == 0) begin : g_pass
      assign al_valid[c]                = acc_valid_in[c];
      assign al_row[c*DATA_W +: DATA_W] = acc_in[c*DATA_W +: DATA_W];
    end else begin : g_dly
      logic [D-1:0]      v_sh;
      logic [DATA_W-1:0] d_sh [D];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          v_sh <= '0;
          for (int unsigned k = 0; k < D; k++) d_sh[k] <= '0;
        end else begin
          v_sh[0] <= acc_valid_in[c];
          d_sh[0] <= acc_in[c*DATA_W +: DATA_W];
          for (int unsigned k = 1; k < D; k++) begin
            v_sh[k] <= v_sh[k-1];
            d_sh[k] <= d_sh[k-1];
          end
        end
      end
      assign al_valid[c]                = v_sh[D-1];
      assign al_row[c*DATA_W +: DATA_W] = d_sh[D-1];
    end
  end

  assign push_req = (state == COLLECT) & ~start & (&al_valid);
  assign skew_hit = (state == COLLECT) & ~start & (|al_valid) & ~(&al_valid);
  assign pop      = out_if.out_valid & out_if.out_ready;

  always_comb begin
    push_data = al_row;
`ifdef RESULT_RELU_EN
    for (int unsigned c = 0; c < N_COLS; c++) begin
      if (al_row[c*DATA_W + DATA_W - 1]) push_data[c*DATA_W +: DATA_W] = '0;
    end
`else
`endif
  end

  sync_fifo #(
    .WIDTH (ROW_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (start),
    .push  (push_req),
    .din   (push_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count),
    .drop  (fifo_drop)
  );

  assign out_if.out_valid = ~fifo_empty;
  assign out_if.out_data  = fifo_dout;
  assign out_if.out_last  = ~fifo_empty & (popped_cnt == target - CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // DRAIN ends when the last stored row leaves; this also terminates jobs
  // whose rows were partly dropped and so never present a last row.
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    unique case (state)
      IDLE:    if (start) state_nx = COLLECT;
      COLLECT: begin
        if (start) state_nx = COLLECT;
        else if (push_req && (pushed_cnt + CNT_W'(1) == target)) state_nx = DRAIN;
      end
      DRAIN: begin
        if (start) state_nx = COLLECT;
        else if (pop && (fifo_count == FCW'(1))) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? COLLECT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target     <= '0;
      pushed_cnt <= '0;
      popped_cnt <= '0;
      overflow   <= 1'b0;
      skew_err   <= 1'b0;
    end else if (start) begin
      target     <= (rows_expected == '0) ? CNT_W'(1) : rows_expected;
      pushed_cnt <= '0;
      popped_cnt <= '0;
      overflow   <= 1'b0;
      skew_err   <= 1'b0;
    end else begin
      if (push_req)  pushed_cnt <= pushed_cnt + CNT_W'(1);
      if (pop)       popped_cnt <= popped_cnt + CNT_W'(1);
      if (fifo_drop) overflow   <= 1'b1;
      if (skew_hit)  skew_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_drain.sv
module tb_result_drain;

  localparam int unsigned DW = 32;
  localparam int unsigned NC = 2;
  localparam int unsigned CW = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [CW-1:0]      rows_expected;
  logic [NC-1:0]      acc_valid_in;
  logic [NC*DW-1:0]   acc_in;
  logic               done, overflow, skew_err;

  result_drain_if #(.DATA_W(DW), .N_COLS(NC)) out_if ();

  result_drain #(
    .DATA_W (DW),
    .N_COLS (NC),
    .DEPTH  (4),
    .CNT_W  (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .rows_expected (rows_expected),
    .acc_valid_in  (acc_valid_in),
    .acc_in        (acc_in),
    .out_if        (out_if),
    .done          (done),
    .overflow      (overflow),
    .skew_err      (skew_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Sink monitor: records every accepted row and done pulses on the falling edge.
  logic [63:0] rx_data[$];
  logic        rx_last[$];
  int ncyc = 0, done_cnt = 0, done_at = -1, last_pop_at = -1;

  always @(negedge clk) begin
    ncyc++;
    if (reset && out_if.out_valid && out_if.out_ready) begin
      rx_data.push_back(out_if.out_data);
      rx_last.push_back(out_if.out_last);
      last_pop_at = ncyc;
    end
    if (done) begin
      done_cnt++;
      done_at = ncyc;
    end
  end

  logic [31:0] r0 [8];
  logic [31:0] r1 [8];

  typedef struct {
    logic [CW-1:0] rexp;
    logic [31:0]   c0, c1;
    logic [31:0]   raw0, raw1;
    logic [31:0]   relu0, relu1;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CW-1:0] n);
    start = 1'b1;
    rows_expected = n;
    tick();
    start = 1'b0;
    rx_data.delete();
    rx_last.delete();
    done_cnt = 0;
  endtask

  // Drives n rows with column 1 one cycle behind column 0.
  task automatic feed(input int n, input int drop_row, input int ready_step, input logic base_ready);
    for (int s = 0; s <= n; s++) begin
      acc_valid_in = '0;
      if (s < n) begin
        acc_valid_in[0] = 1'b1;
        acc_in[31:0]    = r0[s];
      end
      if (s >= 1 && (s - 1) != drop_row) begin
        acc_valid_in[1] = 1'b1;
        acc_in[63:32]   = r1[s-1];
      end
      out_ready = base_ready | (s == ready_step);
      tick();
    end
    acc_valid_in = '0;
    out_ready = base_ready;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      tick();
      k++;
    end
    chk(name, 64'(done_cnt != 0), 64'd1);
    tick();
    tick();
  endtask

  function automatic logic [63:0] rx_at(input int i);
    return (rx_data.size() > i) ? rx_data[i] : 64'hx;
  endfunction

  function automatic logic rxl_at(input int i);
    return (rx_last.size() > i) ? rx_last[i] : 1'bx;
  endfunction

  logic out_ready;
  assign out_if.out_ready = out_ready;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    rows_expected = '0;
    acc_valid_in = '0;
    acc_in = '0;
    out_ready = 1'b0;

    vt[0] = '{8'd1, 32'd81,         32'd127,        32'd81,         32'd127,        32'd81, 32'd127};
    vt[1] = '{8'd1, 32'hFFFF_FFF9,  32'd9,          32'hFFFF_FFF9,  32'd9,          32'd0,  32'd9};
    vt[2] = '{8'd0, 32'h8000_0000,  32'h7FFF_FFFF,  32'h8000_0000,  32'h7FFF_FFFF,  32'd0,  32'h7FFF_FFFF};
    vt[3] = '{8'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd0,  32'd0};
    vt[4] = '{8'd0, 32'd5,          32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFD,  32'd5,  32'd0};

    // Reset state
    tick();
    tick();
    chk("rst_valid", 64'(out_if.out_valid), 64'd0);
    chk("rst_data", out_if.out_data, 64'd0);
    chk("rst_flags", {61'd0, done, overflow, skew_err}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // 1: two-row job, sink always ready
    r0[0] = 32'd81;  r1[0] = 32'd127;
    r0[1] = 32'd151; r1[1] = 32'd237;
    out_ready = 1'b1;
    do_start(8'd2);
    feed(2, -1, -1, 1'b1);
    wait_done("t1_done", 20);
    chk("t1_count", 64'(rx_data.size()), 64'd2);
    chk("t1_row0", rx_at(0), {32'd127, 32'd81});
    chk("t1_row1", rx_at(1), {32'd237, 32'd151});
    chk("t1_last0", 64'(rxl_at(0)), 64'd0);
    chk("t1_last1", 64'(rxl_at(1)), 64'd1);
    chk("t1_done_lat", 64'(done_at - last_pop_at), 64'd1);
    chk("t1_done_pulses", 64'(done_cnt), 64'd1);

    // 2: sink stalled six cycles
    out_ready = 1'b0;
    do_start(8'd2);
    feed(2, -1, -1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("t2_hold_valid", 64'(out_if.out_valid), 64'd1);
      chk("t2_hold_data", out_if.out_data, {32'd127, 32'd81});
      chk("t2_hold_last", 64'(out_if.out_last), 64'd0);
      tick();
    end
    chk("t2_overflow", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    wait_done("t2_done", 20);
    chk("t2_row0", rx_at(0), {32'd127, 32'd81});
    chk("t2_row1", rx_at(1), {32'd237, 32'd151});

    // 3a: six rows into a four-deep FIFO with no pops
    for (int i = 0; i < 6; i++) begin
      r0[i] = 32'(i + 1);
      r1[i] = 32'(i + 101);
    end
    out_ready = 1'b0;
    do_start(8'd6);
    feed(6, -1, -1, 1'b0);
    chk("t3a_overflow", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    wait_done("t3a_done", 20);
    chk("t3a_count", 64'(rx_data.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("t3a_row", rx_at(i), {32'(i + 101), 32'(i + 1)});

    // 3b: five rows, one pop on the full cycle
    out_ready = 1'b0;
    do_start(8'd5);
    chk("t3b_ovf_cleared", 64'(overflow), 64'd0);
    feed(5, -1, 5, 1'b0);
    chk("t3b_overflow", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    wait_done("t3b_done", 20);
    chk("t3b_count", 64'(rx_data.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      chk("t3b_row", rx_at(i), {32'(i + 101), 32'(i + 1)});
    chk("t3b_last", 64'(rxl_at(4)), 64'd1);

    // 4: column 1 valid missing for row 0
    r0[0] = 32'd10; r1[0] = 32'd20;
    r0[1] = 32'd30; r1[1] = 32'd40;
    out_ready = 1'b0;
    do_start(8'd2);
    feed(2, 0, -1, 1'b0);
    chk("t4_skew", 64'(skew_err), 64'd1);
    chk("t4_head", out_if.out_data, {32'd40, 32'd30});
    chk("t4_valid", 64'(out_if.out_valid), 64'd1);
    do_start(8'd1);
    chk("t4_skew_clr", 64'(skew_err), 64'd0);
    chk("t4_flushed", 64'(out_if.out_valid), 64'd0);
    r0[0] = 32'd55; r1[0] = 32'd66;
    out_ready = 1'b1;
    feed(1, -1, -1, 1'b1);
    wait_done("t4_done", 20);
    chk("t4_row", rx_at(0), {32'd66, 32'd55});

    // 5: reset in the middle of DRAIN
    r0[0] = 32'd81;  r1[0] = 32'd127;
    r0[1] = 32'd151; r1[1] = 32'd237;
    out_ready = 1'b0;
    do_start(8'd2);
    feed(2, -1, -1, 1'b0);
    chk("t5_queued", 64'(out_if.out_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(out_if.out_valid), 64'd0);
    chk("t5_rst_data", out_if.out_data, 64'd0);
    chk("t5_rst_last", 64'(out_if.out_last), 64'd0);
    chk("t5_rst_flags", {61'd0, done, overflow, skew_err}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    out_ready = 1'b1;
    do_start(8'd2);
    feed(2, -1, -1, 1'b1);
    wait_done("t5_done", 20);
    chk("t5_row0", rx_at(0), {32'd127, 32'd81});
    chk("t5_row1", rx_at(1), {32'd237, 32'd151});

    // 6: single-row vector table, incl. rows_expected=0 and signed extremes
    for (int v = 0; v < 5; v++) begin
      logic [63:0] exp_row;
`ifdef RESULT_RELU_EN
      exp_row = {vt[v].relu1, vt[v].relu0};
`else
      exp_row = {vt[v].raw1, vt[v].raw0};
`endif
      out_ready = 1'b1;
      do_start(vt[v].rexp);
      r0[0] = vt[v].c0;
      r1[0] = vt[v].c1;
      feed(1, -1, -1, 1'b1);
      wait_done("vec_done", 20);
      chk("vec_count", 64'(rx_data.size()), 64'd1);
      chk("vec_row", rx_at(0), exp_row);
      chk("vec_last", 64'(rxl_at(0)), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
